// File: rtl/inst_sram_arbiter.sv
// inst_sram_arbiter: two-port arbiter in front of the instruction SRAM, one transaction outstanding
module inst_sram_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WAIT   = 4
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    p0_req_i,
  input  logic [ADDR_WIDTH-1:0]   p0_addr_i,
  input  logic                    p0_we_i,
  input  logic [DATA_WIDTH/8-1:0] p0_be_i,
  input  logic [DATA_WIDTH-1:0]   p0_wdata_i,
  output logic                    p0_gnt_o,
  output logic                    p0_rvalid_o,
  output logic [DATA_WIDTH-1:0]   p0_rdata_o,
  input  logic                    p1_req_i,
  input  logic [ADDR_WIDTH-1:0]   p1_addr_i,
  input  logic                    p1_we_i,
  input  logic [DATA_WIDTH/8-1:0] p1_be_i,
  input  logic [DATA_WIDTH-1:0]   p1_wdata_i,
  output logic                    p1_gnt_o,
  output logic                    p1_rvalid_o,
  output logic [DATA_WIDTH-1:0]   p1_rdata_o,
  output logic                    mem_req_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic                    mem_gnt_i,
  input  logic                    mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  output logic                    owner_o,
  output logic                    busy_o,
  output logic                    protocol_err_o
);
  localparam int CW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  typedef enum logic {IDLE, OUTSTANDING} state_e;
  state_e          state_q, state_d;
  logic            owner_q, owner_d;
  logic [CW-1:0]   starv_q, starv_d;
  logic            lock_q, lock_d;
  logic            lock_sel_q, lock_sel_d;
  logic            err_q, err_d;
  logic            busy, lock_hit, sel, grant;
  // Port selection: a pending ungranted request keeps its port, otherwise p0 wins unless p1 has starved
  always_comb begin
    busy      = state_q == OUTSTANDING;
    lock_hit  = lock_q && (lock_sel_q ? p1_req_i : p0_req_i);
    sel       = lock_hit ? lock_sel_q : (p0_req_i && p1_req_i) ? (starv_q == CW'(MAX_WAIT)) : p1_req_i;
    mem_req_o = !reset_i && (p0_req_i || p1_req_i) && (!busy || mem_rvalid_i);
    grant     = mem_req_o && mem_gnt_i;
  end
  assign mem_addr_o     = sel ? p1_addr_i  : p0_addr_i;
  assign mem_we_o       = sel ? p1_we_i    : p0_we_i;
  assign mem_be_o       = sel ? p1_be_i    : p0_be_i;
  assign mem_wdata_o    = sel ? p1_wdata_i : p0_wdata_i;
  assign p0_gnt_o       = grant && !sel;
  assign p1_gnt_o       = grant && sel;
  assign p0_rvalid_o    = mem_rvalid_i && busy && !owner_q;
  assign p1_rvalid_o    = mem_rvalid_i && busy && owner_q;
  assign p0_rdata_o     = mem_rdata_i;
  assign p1_rdata_o     = mem_rdata_i;
  assign owner_o        = owner_q;
  assign busy_o         = busy;
  assign protocol_err_o = err_q;
  // Next state: a grant (re)opens a transaction, a response without a new grant closes it
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    if (grant) begin
      state_d = OUTSTANDING;
      owner_d = sel;
    end else if (busy && mem_rvalid_i) begin
      state_d = IDLE;
    end
    starv_d    = (!p1_req_i || p1_gnt_o) ? '0 : (starv_q == CW'(MAX_WAIT)) ? starv_q : starv_q + CW'(1);
    lock_d     = mem_req_o && !mem_gnt_i;
    lock_sel_d = sel;
    err_d      = err_q || (mem_rvalid_i && !busy);
  end
  // State registers, cleared asynchronously so a reset abandons any outstanding response
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      starv_q    <= '0;
      lock_q     <= 1'b0;
      lock_sel_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      starv_q    <= starv_d;
      lock_q     <= lock_d;
      lock_sel_q <= lock_sel_d;
      err_q      <= err_d;
    end
  end
endmodule

// File: tb/tb_inst_sram_arbiter.sv
// tb_inst_sram_arbiter: directed and randomized checks of the SRAM arbiter against a behavioural model
module tb_inst_sram_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = 4;
  logic clk_i = 1'b0;
  logic reset_i;
  logic p0_req_i, p0_we_i, p0_gnt_o, p0_rvalid_o;
  logic p1_req_i, p1_we_i, p1_gnt_o, p1_rvalid_o;
  logic [AW-1:0] p0_addr_i, p1_addr_i, mem_addr_o;
  logic [DW/8-1:0] p0_be_i, p1_be_i, mem_be_o;
  logic [DW-1:0] p0_wdata_i, p1_wdata_i, p0_rdata_o, p1_rdata_o, mem_wdata_o, mem_rdata_i;
  logic mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i, owner_o, busy_o, protocol_err_o;
  int chk_total = 0;
  int chk_pass = 0;
  bit m_busy, m_owner, m_err, pending;
  int m_wait, m_lock;
  bit e_sel, e_req, e_g0, e_g1, e_rv0, e_rv1;

  always #5 clk_i = ~clk_i;

  inst_sram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(MW)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .p0_req_i(p0_req_i), .p0_addr_i(p0_addr_i), .p0_we_i(p0_we_i), .p0_be_i(p0_be_i), .p0_wdata_i(p0_wdata_i),
    .p0_gnt_o(p0_gnt_o), .p0_rvalid_o(p0_rvalid_o), .p0_rdata_o(p0_rdata_o),
    .p1_req_i(p1_req_i), .p1_addr_i(p1_addr_i), .p1_we_i(p1_we_i), .p1_be_i(p1_be_i), .p1_wdata_i(p1_wdata_i),
    .p1_gnt_o(p1_gnt_o), .p1_rvalid_o(p1_rvalid_o), .p1_rdata_o(p1_rdata_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .owner_o(owner_o), .busy_o(busy_o), .protocol_err_o(protocol_err_o)
  );

  function automatic void model_reset();
    m_busy = 0; m_owner = 0; m_err = 0; m_wait = 0; m_lock = -1; pending = 0;
  endfunction

  function automatic void model_eval();
    if (m_lock >= 0 && (m_lock == 1 ? p1_req_i : p0_req_i)) e_sel = m_lock[0];
    else if (p0_req_i && p1_req_i) e_sel = (m_wait == MW);
    else e_sel = p1_req_i;
    e_req = (p0_req_i || p1_req_i) && (!m_busy || mem_rvalid_i);
    e_g0 = e_req && mem_gnt_i && !e_sel;
    e_g1 = e_req && mem_gnt_i && e_sel;
    e_rv0 = mem_rvalid_i && m_busy && !m_owner;
    e_rv1 = mem_rvalid_i && m_busy && m_owner;
  endfunction

  function automatic void model_advance();
    if (mem_rvalid_i && !m_busy) m_err = 1;
    m_wait = (!p1_req_i || e_g1) ? 0 : (m_wait < MW ? m_wait + 1 : MW);
    m_lock = (e_req && !mem_gnt_i) ? int'(e_sel) : -1;
    if (e_req && mem_gnt_i) begin
      m_busy = 1;
      m_owner = e_sel;
    end else if (m_busy && mem_rvalid_i) m_busy = 0;
  endfunction

  task automatic idle_inputs();
    p0_req_i = 0; p1_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 0;
    p0_addr_i = '0; p1_addr_i = '0; p0_we_i = 0; p1_we_i = 0; p0_be_i = '0; p1_be_i = '0;
    p0_wdata_i = '0; p1_wdata_i = '0; mem_rdata_i = '0;
  endtask

  task automatic step(input bit r0, input bit r1, input bit g, input bit rv, input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    if (pending) model_advance();
    @(negedge clk_i);
    p0_req_i = r0; p1_req_i = r1; mem_gnt_i = g; mem_rvalid_i = rv;
    p0_addr_i = a0; p1_addr_i = a1;
    p0_we_i = 1'($urandom); p1_we_i = 1'($urandom);
    p0_be_i = 4'($urandom); p1_be_i = 4'($urandom);
    p0_wdata_i = $urandom; p1_wdata_i = $urandom; mem_rdata_i = $urandom;
    #1 model_eval();
    pending = 1;
  endtask

  task automatic do_reset();
    reset_i = 1;
    idle_inputs();
    model_reset();
    repeat (2) @(negedge clk_i);
    reset_i = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_i = 1; p0_req_i = 1; p1_req_i = 1; mem_gnt_i = 1; mem_rvalid_i = 1;
    #1;
    chk_total++;
    if ({mem_req_o, p0_gnt_o, p1_gnt_o, p0_rvalid_o, p1_rvalid_o, busy_o, owner_o, protocol_err_o} !== 8'b0)
      $display("FAIL reset_outputs: got %b want 00000000", {mem_req_o, p0_gnt_o, p1_gnt_o, p0_rvalid_o, p1_rvalid_o, busy_o, owner_o, protocol_err_o});
    else chk_pass++;
    do_reset();
    #1;
    chk_total++;
    if ({mem_req_o, busy_o, owner_o, protocol_err_o} !== 4'b0)
      $display("FAIL reset_release: got %b want 0000", {mem_req_o, busy_o, owner_o, protocol_err_o});
    else chk_pass++;
  endtask

  task automatic test_single_read();
    step(1, 0, 1, 0, 32'h100, 32'h200);
    chk_total++;
    if ({mem_req_o, p0_gnt_o, p1_gnt_o} !== 3'b110 || mem_addr_o !== 32'h100 || mem_we_o !== p0_we_i || mem_be_o !== p0_be_i || mem_wdata_o !== p0_wdata_i)
      $display("FAIL single_grant: req/g0/g1 %b addr %h want 110 addr 00000100", {mem_req_o, p0_gnt_o, p1_gnt_o}, mem_addr_o);
    else chk_pass++;
    step(0, 0, 0, 1, 32'h0, 32'h0);
    mem_rdata_i = 32'hDEADBEEF;
    #1;
    chk_total++;
    if ({p0_rvalid_o, p1_rvalid_o} !== 2'b10 || p0_rdata_o !== 32'hDEADBEEF)
      $display("FAIL single_resp: rv %b data %h want 10 deadbeef", {p0_rvalid_o, p1_rvalid_o}, p0_rdata_o);
    else chk_pass++;
    step(0, 0, 0, 0, 32'h0, 32'h0);
    chk_total++;
    if ({busy_o, owner_o} !== 2'b00) $display("FAIL single_idle: busy/owner %b want 00", {busy_o, owner_o});
    else chk_pass++;
  endtask

  task automatic test_starvation();
    logic [1:0] want;
    for (int i = 0; i < 10; i++) begin
      step(1, 1, 1, i > 0, $urandom, $urandom);
      want = (i % 5 == 4) ? 2'b01 : 2'b10;
      chk_total++;
      if ({p0_gnt_o, p1_gnt_o} !== want) $display("FAIL starve_cycle%0d: g0g1 %b want %b", i, {p0_gnt_o, p1_gnt_o}, want);
      else chk_pass++;
    end
    step(0, 0, 0, 1, 0, 0);
    chk_total++;
    if ({p0_rvalid_o, p1_rvalid_o} !== 2'b01) $display("FAIL starve_drain: rv %b want 01", {p0_rvalid_o, p1_rvalid_o});
    else chk_pass++;
    step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_lock();
    bit r0_t[5] = '{0, 1, 1, 1, 1};
    bit r1_t[5] = '{1, 1, 1, 1, 0};
    bit g_t[5]  = '{0, 0, 0, 1, 1};
    bit rv_t[5] = '{0, 0, 0, 0, 1};
    logic [1:0] gw_t[5] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b10};
    logic [AW-1:0] a0 = 32'h0000_B0B0;
    logic [AW-1:0] a1 = 32'hA1A1_0000;
    for (int i = 0; i < 5; i++) begin
      step(r0_t[i], r1_t[i], g_t[i], rv_t[i], a0, a1);
      chk_total++;
      if ({p0_gnt_o, p1_gnt_o} !== gw_t[i] || mem_req_o !== 1'b1 || mem_addr_o !== (i < 4 ? a1 : a0))
        $display("FAIL lock_cycle%0d: g0g1 %b req %b addr %h want %b 1 %h", i, {p0_gnt_o, p1_gnt_o}, mem_req_o, mem_addr_o, gw_t[i], (i < 4 ? a1 : a0));
      else chk_pass++;
    end
    chk_total++;
    if ({p0_rvalid_o, p1_rvalid_o} !== 2'b01) $display("FAIL lock_p1_resp: rv %b want 01", {p0_rvalid_o, p1_rvalid_o});
    else chk_pass++;
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    bit k, prev;
    for (int i = 0; i < 10; i++) begin
      k = (i < 4) ? 1'b0 : 1'($urandom);
      step(!k, k, 1, i > 0, $urandom, $urandom);
      chk_total++;
      if ({p0_gnt_o, p1_gnt_o} !== (k ? 2'b01 : 2'b10)) $display("FAIL b2b_grant%0d: g0g1 %b want %b", i, {p0_gnt_o, p1_gnt_o}, (k ? 2'b01 : 2'b10));
      else chk_pass++;
      if (i > 0) begin
        chk_total++;
        if ({busy_o, owner_o, p0_rvalid_o, p1_rvalid_o} !== {1'b1, prev, !prev, prev})
          $display("FAIL b2b_resp%0d: busy/owner/rv %b want %b", i, {busy_o, owner_o, p0_rvalid_o, p1_rvalid_o}, {1'b1, prev, !prev, prev});
        else chk_pass++;
      end
      prev = k;
    end
    step(0, 0, 0, 1, 0, 0);
    chk_total++;
    if ({p0_rvalid_o, p1_rvalid_o} !== {!prev, prev}) $display("FAIL b2b_drain: rv %b want %b", {p0_rvalid_o, p1_rvalid_o}, {!prev, prev});
    else chk_pass++;
    step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_release();
    step(0, 1, 0, 0, 32'h40, 32'h80);
    step(1, 0, 1, 0, 32'h40, 32'h80);
    chk_total++;
    if ({p0_gnt_o, p1_gnt_o} !== 2'b10 || mem_addr_o !== 32'h40)
      $display("FAIL release: g0g1 %b addr %h want 10 00000040", {p0_gnt_o, p1_gnt_o}, mem_addr_o);
    else chk_pass++;
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_protocol_err();
    step(0, 0, 0, 1, 0, 0);
    chk_total++;
    if ({p0_rvalid_o, p1_rvalid_o, protocol_err_o} !== 3'b000) $display("FAIL perr_drop: rv/err %b want 000", {p0_rvalid_o, p1_rvalid_o, protocol_err_o});
    else chk_pass++;
    step(1, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk_total++;
    if ({protocol_err_o, busy_o} !== 2'b10) $display("FAIL perr_sticky: err/busy %b want 10", {protocol_err_o, busy_o});
    else chk_pass++;
  endtask

  task automatic test_reset_mid();
    step(1, 1, 1, 0, 32'h10, 32'h20);
    repeat (3) step(1, 1, 0, 0, 32'h10, 32'h20);
    chk_total++;
    if ({busy_o, mem_req_o} !== 2'b10) $display("FAIL mid_busy: busy/req %b want 10", {busy_o, mem_req_o});
    else chk_pass++;
    #2 reset_i = 1;
    #1;
    chk_total++;
    if ({busy_o, owner_o, mem_req_o, p0_gnt_o, p1_gnt_o, protocol_err_o} !== 6'b0)
      $display("FAIL mid_async: got %b want 000000", {busy_o, owner_o, mem_req_o, p0_gnt_o, p1_gnt_o, protocol_err_o});
    else chk_pass++;
    idle_inputs();
    model_reset();
    @(negedge clk_i);
    reset_i = 0;
    step(1, 1, 0, 1, 32'h10, 32'h20);
    chk_total++;
    if ({p0_rvalid_o, p1_rvalid_o} !== 2'b00 || mem_addr_o !== 32'h10)
      $display("FAIL mid_abandon: rv %b addr %h want 00 00000010", {p0_rvalid_o, p1_rvalid_o}, mem_addr_o);
    else chk_pass++;
    step(1, 1, 1, 0, 32'h10, 32'h20);
    chk_total++;
    if ({p0_gnt_o, p1_gnt_o, protocol_err_o} !== 3'b101) $display("FAIL mid_after: g0g1/err %b want 101", {p0_gnt_o, p1_gnt_o, protocol_err_o});
    else chk_pass++;
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    bit r0, r1, g, rv;
    int bad = 0;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      r0 = ($urandom % 4) != 0;
      r1 = ($urandom % 3) != 0;
      g = ($urandom % 4) != 0;
      rv = m_busy ? (($urandom % 3) != 0) : (($urandom % 50) == 0);
      step(r0, r1, g, rv, $urandom, $urandom);
      chk_total++;
      if ({mem_req_o, p0_gnt_o, p1_gnt_o, p0_rvalid_o, p1_rvalid_o, busy_o, owner_o, protocol_err_o} !==
          {e_req, e_g0, e_g1, e_rv0, e_rv1, m_busy, m_owner, m_err} ||
          mem_addr_o !== (e_sel ? p1_addr_i : p0_addr_i) || mem_we_o !== (e_sel ? p1_we_i : p0_we_i) ||
          mem_be_o !== (e_sel ? p1_be_i : p0_be_i) || mem_wdata_o !== (e_sel ? p1_wdata_i : p0_wdata_i) ||
          p0_rdata_o !== mem_rdata_i || p1_rdata_o !== mem_rdata_i) begin
        if (bad < 10)
          $display("FAIL random_cycle%0d: ctl %b addr %h want ctl %b sel %0d", i,
                   {mem_req_o, p0_gnt_o, p1_gnt_o, p0_rvalid_o, p1_rvalid_o, busy_o, owner_o, protocol_err_o}, mem_addr_o,
                   {e_req, e_g0, e_g1, e_rv0, e_rv1, m_busy, m_owner, m_err}, e_sel);
        bad++;
      end else chk_pass++;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_read();
    test_starvation();
    test_lock();
    test_back_to_back();
    test_release();
    test_protocol_err();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", chk_pass, chk_total);
    $finish;
  end
endmodule
